// File: rtl/rdma_meta_rx_router.sv
// RDMA RX meta router: steers one vfid-tagged input stream into per-region FIFOs,
// drops and counts words whose vfid does not name a region.
module rdma_meta_rx_router #(
    parameter int N_REGIONS = 4,
    parameter int VFID_BITS = 4,
    parameter int DATA_BITS = 256,
    parameter int DEPTH     = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_BITS-1:0]           s_data,
    input  logic [VFID_BITS-1:0]           s_vfid,
    output logic [N_REGIONS-1:0]           m_valid,
    input  logic [N_REGIONS-1:0]           m_ready,
    output logic [N_REGIONS*DATA_BITS-1:0] m_data,
    output logic                           drop_pulse,
    output logic [31:0]                    drop_cnt,
    output logic [31:0]                    rx_cnt
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_BITS = PTR_BITS + 1;

    logic [DATA_BITS-1:0] mem    [N_REGIONS][DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr [N_REGIONS];
    logic [PTR_BITS-1:0]  rd_ptr [N_REGIONS];
    logic [OCC_BITS-1:0]  occ    [N_REGIONS];
    logic [N_REGIONS-1:0] full;
    logic [N_REGIONS-1:0] push;
    logic [N_REGIONS-1:0] pop;
    logic                 valid_id;
    logic                 head_full;
    logic                 accept;

    // Ready looks only at registered occupancy: a full FIFO popped this cycle
    // still refuses, trading one bubble for no m_ready->s_ready path.
    always_comb begin
        valid_id  = (32'(s_vfid) < N_REGIONS);
        head_full = 1'b0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (32'(s_vfid) == i) head_full = full[i];
        end
    end

    assign s_ready = aresetn & (~valid_id | ~head_full);
    assign accept  = s_valid & s_ready;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
        assign full[g]    = (occ[g] == OCC_BITS'(DEPTH));
        assign m_valid[g] = (occ[g] != '0);
        assign push[g]    = accept & valid_id & (32'(s_vfid) == g);
        assign pop[g]     = m_valid[g] & m_ready[g];
        assign m_data[g*DATA_BITS +: DATA_BITS] = mem[g][rd_ptr[g]];

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                wr_ptr[g] <= '0;
                rd_ptr[g] <= '0;
                occ[g]    <= '0;
            end else begin
                if (push[g]) wr_ptr[g] <= wr_ptr[g] + 1'b1;
                if (pop[g])  rd_ptr[g] <= rd_ptr[g] + 1'b1;
                if (push[g] && !pop[g])      occ[g] <= occ[g] + 1'b1;
                else if (!push[g] && pop[g]) occ[g] <= occ[g] - 1'b1;
            end
        end

        // Storage carries no reset; occupancy alone decides what is visible.
        always_ff @(posedge aclk) begin
            if (push[g]) mem[g][wr_ptr[g]] <= s_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
            rx_cnt     <= '0;
        end else begin
            drop_pulse <= accept & ~valid_id;
            if (accept && valid_id) rx_cnt <= rx_cnt + 32'd1;
            if (accept && !valid_id && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
        end
    end

endmodule
